// File: rtl/tk1_spi_flash_reader_pkg.sv
// Shared opcodes and FSM/byte-phase encodings for the tk1 SPI flash reader.
// TK1_SPI_FLASH_FAST_READ_EN adds the DUMMY state encoding.
package tk1_spi_flash_reader_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [3:0] {
    ST_DESEL_INIT = 4'd0,
    ST_IDLE       = 4'd1,
    ST_SELECT     = 4'd2,
    ST_CMD        = 4'd3,
    ST_ADDR2      = 4'd4,
    ST_ADDR1      = 4'd5,
    ST_ADDR0      = 4'd6,
`ifdef TK1_SPI_FLASH_FAST_READ_EN
    ST_DUMMY      = 4'd7,
`endif
    ST_DATA       = 4'd8,
    ST_DESELECT   = 4'd9,
    ST_GAP        = 4'd10,
    ST_DONE       = 4'd11
  } fsm_state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WAIT0 = 2'd1,
    PH_WAIT  = 2'd2,
    PH_DONE  = 2'd3
  } byte_phase_e;

endpackage

// File: rtl/tk1_spi_byte_issue.sv
// One SPI byte transfer against the tk1 master: start strobe when the master is idle,
// skip the stale ready cycle, capture rx on completion and pulse byte_done_o.
module tk1_spi_byte_issue
  import tk1_spi_flash_reader_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       go_i,
  input  logic [7:0] tx_byte_i,
  input  logic       spi_ready_i,
  input  logic [7:0] spi_rx_data_i,
  output logic       spi_start_o,
  output logic [7:0] spi_tx_data_o,
  output logic       spi_tx_data_vld_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  byte_phase_e phase_q, phase_d;
  logic [7:0]  rx_q, rx_d;

  always_comb begin
    phase_d           = phase_q;
    rx_d              = rx_q;
    spi_start_o       = 1'b0;
    spi_tx_data_o     = 8'h00;
    spi_tx_data_vld_o = 1'b0;
    byte_done_o       = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (go_i && spi_ready_i) begin
          spi_start_o       = 1'b1;
          spi_tx_data_o     = tx_byte_i;
          spi_tx_data_vld_o = 1'b1;
          phase_d           = PH_WAIT0;
        end
      end
      // ready may still read high from the previous byte in this cycle
      PH_WAIT0: phase_d = PH_WAIT;
      PH_WAIT: begin
        if (spi_ready_i) begin
          rx_d    = spi_rx_data_i;
          phase_d = PH_DONE;
        end
      end
      PH_DONE: begin
        byte_done_o = 1'b1;
        phase_d     = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= PH_IDLE;
      rx_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      rx_q    <= rx_d;
    end
  end

  assign rx_byte_o = rx_q;

endmodule

// File: rtl/tk1_spi_flash_reader.sv
// Flash read sequencer: select, opcode + 24-bit address, cmd_len data bytes, deselect, tSHSL gap.
// TK1_SPI_FLASH_FAST_READ_EN switches to opcode 0x0B with one dummy byte before data.
module tk1_spi_flash_reader
  import tk1_spi_flash_reader_pkg::*;
#(
  parameter int         LEN_W   = 12,
  parameter int         CS_GAP  = 4,
  parameter logic [7:0] READ_OP = OP_READ
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_start_i,
  input  logic [23:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             spi_enable_o,
  output logic             spi_enable_vld_o,
  output logic             spi_start_o,
  output logic [7:0]       spi_tx_data_o,
  output logic             spi_tx_data_vld_o,
  input  logic [7:0]       spi_rx_data_i,
  input  logic             spi_ready_i
);

`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] CMD_OP = OP_FAST_READ;
`else
  localparam logic [7:0] CMD_OP = READ_OP;
`endif
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  fsm_state_e       state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic       byte_go;
  logic       byte_done;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;

  tk1_spi_byte_issue u_byte_issue (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .go_i             (byte_go),
    .tx_byte_i        (tx_byte),
    .spi_ready_i      (spi_ready_i),
    .spi_rx_data_i    (spi_rx_data_i),
    .spi_start_o      (spi_start_o),
    .spi_tx_data_o    (spi_tx_data_o),
    .spi_tx_data_vld_o(spi_tx_data_vld_o),
    .byte_done_o      (byte_done),
    .rx_byte_o        (rx_byte)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    case (state_q)
      ST_DESEL_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_start_i) begin
          if (cmd_len_i == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = cmd_addr_i;
            cnt_d   = cmd_len_i;
            state_d = ST_SELECT;
          end
        end
      end
      ST_SELECT: state_d = ST_CMD;
      ST_CMD:    if (byte_done) state_d = ST_ADDR2;
      ST_ADDR2:  if (byte_done) state_d = ST_ADDR1;
      ST_ADDR1:  if (byte_done) state_d = ST_ADDR0;
`ifdef TK1_SPI_FLASH_FAST_READ_EN
      ST_ADDR0:  if (byte_done) state_d = ST_DUMMY;
      ST_DUMMY:  if (byte_done) state_d = ST_DATA;
`else
      ST_ADDR0:  if (byte_done) state_d = ST_DATA;
`endif
      ST_DATA: begin
        if (byte_done) begin
          rd_data_d  = rx_byte;
          rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready_i) begin
          rd_valid_d = 1'b0;
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_DESELECT;
        end
      end
      ST_DESELECT: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_DONE;
        else gap_d = gap_q + GAP_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_DESEL_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_DESEL_INIT;
      addr_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // A DATA byte is only requested once the previous one has been handed off.
  always_comb begin
    byte_go = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      ST_CMD:   begin byte_go = 1'b1; tx_byte = CMD_OP;        end
      ST_ADDR2: begin byte_go = 1'b1; tx_byte = addr_q[23:16]; end
      ST_ADDR1: begin byte_go = 1'b1; tx_byte = addr_q[15:8];  end
      ST_ADDR0: begin byte_go = 1'b1; tx_byte = addr_q[7:0];   end
`ifdef TK1_SPI_FLASH_FAST_READ_EN
      ST_DUMMY: byte_go = 1'b1;
`endif
      ST_DATA:  byte_go = !rd_valid_q;
      default:  byte_go = 1'b0;
    endcase
  end

  assign busy_o           = (state_q != ST_DESEL_INIT) && (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o           = (state_q == ST_DONE);
  assign spi_enable_o     = (state_q == ST_SELECT);
  assign spi_enable_vld_o = (state_q == ST_DESEL_INIT) || (state_q == ST_SELECT) || (state_q == ST_DESELECT);
  assign rd_data_o        = rd_data_q;
  assign rd_valid_o       = rd_valid_q;

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Directed bench for tk1_spi_flash_reader with a behavioural byte master and flash model.
// Build with TK1_SPI_FLASH_FAST_READ_EN to check the fast-read framing.
module tb_tk1_spi_flash_reader;

`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [23:0] cmd_addr = 24'h0;
  logic [11:0] cmd_len = 12'h0;
  logic        busy, done, rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready = 1'b1;
  logic        spi_enable, spi_enable_vld, spi_start, spi_tx_data_vld;
  logic [7:0]  spi_tx_data;
  logic [7:0]  spi_rx_data = 8'h00;
  logic        spi_ready = 1'b1;

  int n_vec = 0;
  int n_miscompare = 0;

  always #5 clk = ~clk;

  tk1_spi_flash_reader dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .cmd_start_i      (cmd_start),
    .cmd_addr_i       (cmd_addr),
    .cmd_len_i        (cmd_len),
    .busy_o           (busy),
    .done_o           (done),
    .rd_data_o        (rd_data),
    .rd_valid_o       (rd_valid),
    .rd_ready_i       (rd_ready),
    .spi_enable_o     (spi_enable),
    .spi_enable_vld_o (spi_enable_vld),
    .spi_start_o      (spi_start),
    .spi_tx_data_o    (spi_tx_data),
    .spi_tx_data_vld_o(spi_tx_data_vld),
    .spi_rx_data_i    (spi_rx_data),
    .spi_ready_i      (spi_ready)
  );

  // flash contents: mem[a] = a ^ 5C except a hand-placed pattern at 0x45..0x48
  logic [7:0] mem [256];
  logic [7:0] exp_main [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
    mem[8'h45] = 8'hA5;
    mem[8'h46] = 8'h5A;
    mem[8'h47] = 8'hC3;
    mem[8'h48] = 8'h3C;
  end

  // byte master (3 busy cycles per byte) + flash
  logic [7:0]  mosi_log [256];
  int          mosi_n = 0;
  int          mcnt = 0;
  int          bidx = 0;
  logic [7:0]  pend = 8'h00;
  logic [23:0] faddr = 24'h0;

  always @(posedge clk) begin
    if (spi_enable_vld && spi_enable) bidx <= 0;
    if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        spi_ready   <= 1'b1;
        spi_rx_data <= pend;
      end
    end else if (spi_start && spi_tx_data_vld && spi_ready) begin
      mosi_log[mosi_n[7:0]] <= spi_tx_data;
      mosi_n    <= mosi_n + 1;
      spi_ready <= 1'b0;
      mcnt      <= 3;
      bidx      <= bidx + 1;
      if (bidx == 1) faddr[23:16] <= spi_tx_data;
      if (bidx == 2) faddr[15:8]  <= spi_tx_data;
      if (bidx == 3) faddr[7:0]   <= spi_tx_data;
      pend <= (bidx >= HDR) ? mem[faddr[7:0] + 8'(bidx - HDR)] : 8'h00;
    end
  end

  // monitors
  logic [7:0] rd_log [256];
  int rd_n = 0, start_cnt = 0, vld_cnt = 0, done_cnt = 0;
  int cyc = 0, desel_cyc = 0, done_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_valid && rd_ready) begin
      rd_log[rd_n[7:0]] <= rd_data;
      rd_n <= rd_n + 1;
    end
    if (spi_start) start_cnt <= start_cnt + 1;
    if (spi_enable_vld) vld_cnt <= vld_cnt + 1;
    if (spi_enable_vld && !spi_enable) desel_cyc <= cyc;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_cmd(input logic [23:0] a, input logic [11:0] l);
    $display("cmd addr=%06h len=%0d t=%0t", a, l, $time);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (done) got = 1'b1;
      else tick(1);
    end
    check_eq(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_rd_valid(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (rd_valid) got = 1'b1;
      else tick(1);
    end
    check_eq(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int m0, r0, s0, s1, v0, d0;

    // reset release
    tick(3);
    reset = 1'b0;
    check_eq("rst_en_vld", 32'(spi_enable_vld), 32'd1);
    check_eq("rst_en", 32'(spi_enable), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_start", 32'(spi_start), 32'd0);
    tick(1);
    check_eq("rst_en_vld_drop", 32'(spi_enable_vld), 32'd0);
    tick(2);

    // basic 4-byte read
    m0 = mosi_n; r0 = rd_n;
    pulse_cmd(24'h012345, 12'd4);
    check_eq("main_busy", 32'(busy), 32'd1);
    wait_done("main_done", 400);
    check_eq("main_done_busy", 32'(busy), 32'd0);
    tick(1);
    check_eq("main_done_pulse", 32'(done), 32'd0);
    check_eq("main_gap", 32'(done_cyc - desel_cyc), 32'd5);
    check_eq("main_mosi_n", 32'(mosi_n - m0), 32'(HDR + 4));
    check_eq("main_op", 32'(mosi_log[8'(m0)]), 32'(OPC));
    check_eq("main_a2", 32'(mosi_log[8'(m0 + 1)]), 32'h01);
    check_eq("main_a1", 32'(mosi_log[8'(m0 + 2)]), 32'h23);
    check_eq("main_a0", 32'(mosi_log[8'(m0 + 3)]), 32'h45);
    for (int k = 4; k < HDR + 4; k++)
      check_eq("main_tx_zero", 32'(mosi_log[8'(m0 + k)]), 32'h00);
    check_eq("main_rd_n", 32'(rd_n - r0), 32'd4);
    for (int k = 0; k < 4; k++)
      check_eq("main_rd", 32'(rd_log[8'(r0 + k)]), 32'(exp_main[k]));

    // zero length
    tick(2);
    v0 = vld_cnt; s0 = start_cnt;
    pulse_cmd(24'h000000, 12'd0);
    check_eq("len0_done", 32'(done), 32'd1);
    check_eq("len0_busy", 32'(busy), 32'd0);
    tick(1);
    check_eq("len0_done_pulse", 32'(done), 32'd0);
    tick(3);
    check_eq("len0_no_vld", 32'(vld_cnt - v0), 32'd0);
    check_eq("len0_no_start", 32'(start_cnt - s0), 32'd0);

    // consumer stall
    m0 = mosi_n; r0 = rd_n;
    rd_ready = 1'b0;
    pulse_cmd(24'h000010, 12'd3);
    wait_rd_valid("stall_first", 400);
    tick(1);
    s0 = start_cnt;
    tick(20);
    check_eq("stall_no_start", 32'(start_cnt - s0), 32'd0);
    check_eq("stall_valid", 32'(rd_valid), 32'd1);
    check_eq("stall_data", 32'(rd_data), 32'h4C);
    s1 = start_cnt;
    rd_ready = 1'b1;
    wait_done("stall_done", 400);
    check_eq("stall_more_starts", 32'(start_cnt - s1), 32'd2);
    check_eq("stall_mosi_n", 32'(mosi_n - m0), 32'(HDR + 3));
    check_eq("stall_rd_n", 32'(rd_n - r0), 32'd3);
    check_eq("stall_rd0", 32'(rd_log[8'(r0)]), 32'h4C);
    check_eq("stall_rd1", 32'(rd_log[8'(r0 + 1)]), 32'h4D);
    check_eq("stall_rd2", 32'(rd_log[8'(r0 + 2)]), 32'h4E);

    // cmd_start while busy is dropped
    tick(2);
    m0 = mosi_n; r0 = rd_n;
    pulse_cmd(24'h000020, 12'd2);
    tick(8);
    check_eq("ovl_busy", 32'(busy), 32'd1);
    pulse_cmd(24'h000100, 12'd5);
    wait_done("ovl_done", 400);
    tick(6);
    check_eq("ovl_idle", 32'(busy), 32'd0);
    check_eq("ovl_mosi_n", 32'(mosi_n - m0), 32'(HDR + 2));
    check_eq("ovl_a1", 32'(mosi_log[8'(m0 + 2)]), 32'h00);
    check_eq("ovl_a0", 32'(mosi_log[8'(m0 + 3)]), 32'h20);
    check_eq("ovl_rd_n", 32'(rd_n - r0), 32'd2);
    check_eq("ovl_rd0", 32'(rd_log[8'(r0)]), 32'h7C);
    check_eq("ovl_rd1", 32'(rd_log[8'(r0 + 1)]), 32'h7D);

    // reset in the middle of DATA
    rd_ready = 1'b0;
    pulse_cmd(24'h000030, 12'd4);
    wait_rd_valid("mrst_in_data", 400);
    d0 = done_cnt;
    $display("reset mid-data t=%0t", $time);
    reset = 1'b1;
    tick(1);
    check_eq("mrst_en_vld", 32'(spi_enable_vld), 32'd1);
    check_eq("mrst_en", 32'(spi_enable), 32'd0);
    check_eq("mrst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rd_ready = 1'b1;
    tick(20);
    check_eq("mrst_no_done", 32'(done_cnt - d0), 32'd0);

    // single byte from address 0 after recovery
    m0 = mosi_n; r0 = rd_n;
    pulse_cmd(24'h000000, 12'd1);
    wait_done("one_done", 400);
    check_eq("one_mosi_n", 32'(mosi_n - m0), 32'(HDR + 1));
    check_eq("one_op", 32'(mosi_log[8'(m0)]), 32'(OPC));
    for (int k = 1; k < HDR + 1; k++)
      check_eq("one_tx_zero", 32'(mosi_log[8'(m0 + k)]), 32'h00);
    check_eq("one_rd_n", 32'(rd_n - r0), 32'd1);
    check_eq("one_rd", 32'(rd_log[8'(r0)]), 32'h5C);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
